adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one external 32-bit carry-lookahead adder among NREQ requesters.
- Each requester presents operands A, B and a carry-in with a valid/ready handshake.
- The block latches the winning operands and drives them onto the adder for a programmable number of settle cycles, treating the adder as a multi-cycle path.
- It then returns the sum and carry-out, tagged with the requester ID, on a single response channel with backpressure.

Parameters:
- NREQ, 4, number of requesters; supported range 2..8.
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.
- SETTLE, 2, cycles operands are held on the adder before the result is sampled; supported range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  32*NREQ  packed operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NREQ  packed operand B, same packing as req_a.
- req_cin  in  NREQ  per-requester carry-in.
- add_a  out  32  operand A to the shared adder.
- add_b  out  32  operand B to the shared adder.
- add_cin  out  1  carry-in to the shared adder.
- add_sum  in  32  sum from the shared adder.
- add_cout  in  1  carry-out (Z) from the shared adder.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_sum  out  32  registered sum.
- rsp_cout  out  1  registered carry-out.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - FSM goes to IDLE; round-robin pointer = 0.
  - Settle counter = 0.
  - add_a, add_b, add_cin, rsp_sum, rsp_cout, rsp_id = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0.
- Reset asserted mid-operation abandons the transaction. No response is emitted for it, and the requester must re-present its request.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first valid requester found searching from the pointer upward, with modulo-NREQ wrap.
  - If no requester is valid, req_ready = 0.
  - On a handshake (req_valid[i] & req_ready[i]) at the clock edge, the block:
    - registers the requester's A/B/cin onto add_a/add_b/add_cin;
    - sets the ID to i and the pointer to (i+1) mod NREQ;
    - loads the counter with SETTLE-1 and moves to ADD.
- ADD:
  - req_ready = 0; add_* are held stable.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0, add_sum/add_cout are captured into rsp_sum/rsp_cout, rsp_valid is set and the FSM moves to RESP.
  - With SETTLE=1 the capture occurs on the first ADD cycle.
  - First request accept to rsp_valid high = SETTLE+1 clock edges.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_sum and rsp_cout are held stable until handshake.
  - On rsp_valid & rsp_ready, rsp_valid clears next cycle and the FSM returns to IDLE.
  - No new request is accepted in that same cycle; the minimum issue interval is SETTLE+2 cycles.
- add_a, add_b and add_cin keep their last values in IDLE and RESP. They change only on acceptance.
- A requester deasserting req_valid before it is granted is legal and is simply not granted. Once valid is high, the requester's operands must stay stable until accepted.
- Arithmetic: results are 32-bit modulo 2^32, with the carry-out reported separately. The block performs no arithmetic itself.
- Requester indices >= NREQ are never granted.
- Fairness: a continuously requesting requester is served within NREQ transactions.

Test Plan:
- Single request: requester 0, A=0x0000_0005, B=0x0000_0003, cin=0, SETTLE=2 -> rsp_valid 3 edges after accept; rsp_id=0, rsp_sum=0x0000_0008, rsp_cout=0.
- Carry-out and wrap: requester 2, A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> rsp_sum=0x0000_0000, rsp_cout=1, rsp_id=2.
- Round-robin: all four requesters valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Issue interval = 4 cycles; no requester starved.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_sum and rsp_id held constant; req_ready stays 0 throughout; the next grant occurs only after the handshake.
- Pointer wrap and skip: pointer=3 with requesters 1 and 3 valid -> grant 3 first, then 1.
- Mid-operation reset: assert rst during ADD with requester 1 active -> all outputs 0 immediately; pointer=0. After release, a request from requester 0 with A=0x1234_5678, B=0x1111_1111 -> rsp_sum=0x2345_6789.

Source files
------------

// File: rtl/adder_share_arb.sv
// Round-robin sequencer that time-shares one external 32-bit adder among NREQ requesters.
// Winning operands are held on the adder for SETTLE cycles before the result is sampled.
module adder_share_arb #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned IDW    = 2,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]      req_cin,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   output logic                 add_cin,
   input  logic [31:0]          add_sum,
   input  logic                 add_cout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_sum,
   output logic                 rsp_cout,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     add_a_q, add_a_d;
   logic [31:0]     add_b_q, add_b_d;
   logic            add_cin_q, add_cin_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [31:0]     rsp_sum_q, rsp_sum_d;
   logic            rsp_cout_q, rsp_cout_d;
   logic            busy_q, busy_d;

   logic            found_hi, found_lo, found;
   logic [IDW-1:0]  id_hi, id_lo, grant_id;
   logic [31:0]     sel_a, sel_b;
   logic            sel_cin;

   // Two-pass search: first valid at or above the pointer, else first valid overall (wrap).
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      id_hi    = '0;
      id_lo    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            if (!found_hi && (IDW'(i) >= ptr_q)) begin
               found_hi = 1'b1;
               id_hi    = IDW'(i);
            end
            if (!found_lo) begin
               found_lo = 1'b1;
               id_lo    = IDW'(i);
            end
         end
      end
      found    = found_hi | found_lo;
      grant_id = found_hi ? id_hi : id_lo;
   end

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_cin = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_a   = req_a[32*i +: 32];
            sel_b   = req_b[32*i +: 32];
            sel_cin = req_cin[i];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if ((state_q == S_IDLE) && found) begin
         req_ready = NREQ'(1) << grant_id;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_cin_d   = add_cin_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               add_a_d   = sel_a;
               add_b_d   = sel_b;
               add_cin_d = sel_cin;
               rsp_id_d  = grant_id;
               ptr_d     = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
               cnt_d     = 4'(SETTLE-1);
               state_d   = S_ADD;
            end
         end
         S_ADD: begin
            if (cnt_q == '0) begin
               rsp_sum_d   = add_sum;
               rsp_cout_d  = add_cout;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cin_q   <= add_cin_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
         busy_q      <= busy_d;
      end
   end

   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios plus random traffic against a
// transaction-level model of arbitration order, latency, holding and arithmetic.
module tb_adder_share_arb;
   localparam int unsigned NREQ   = 4;
   localparam int unsigned IDW    = 2;
   localparam int unsigned SETTLE = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     rv, rc, req_ready;
   logic [32*NREQ-1:0]  ra, rb;
   logic [31:0]         add_a, add_b, add_sum;
   logic                add_cin, add_cout;
   logic                rsp_valid, rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_sum;
   logic                rsp_cout, busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adder_share_arb #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .req_valid(rv), .req_ready(req_ready),
      .req_a(ra), .req_b(rb), .req_cin(rc),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .busy(busy)
   );

   // External adder whose output lags its operands by one clock, so an early sample reads a stale sum.
   always @(posedge clk) begin
      {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Model state, owned by the monitor
   int unsigned     glog[$];
   int              acc_log[$];
   int              cyc = 0;
   int              acc_cyc = 0;
   int              rsp_cnt = 0;
   bit              inflt = 0;
   int unsigned     mptr = 0;
   int unsigned     cur_id;
   logic [31:0]     cur_a, cur_b;
   logic            cur_c;
   logic [32:0]     cur_res;
   int unsigned     last_id;
   logic [31:0]     last_sum;
   logic            last_cout;
   int              wait_n[NREQ];
   bit              prev_rv = 0;
   logic [IDW-1:0]  h_id;
   logic [31:0]     h_sum;
   logic            h_cout;

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      int              g;
      cyc++;
      if (rst) begin
         inflt   = 0;
         mptr    = 0;
         prev_rv = 0;
         for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
      end else begin
         exp_rdy = '0;
         g       = -1;
         if (!inflt) begin
            for (int k = 0; k < NREQ; k++) begin
               int unsigned idx;
               idx = (mptr + k) % NREQ;
               if (g < 0 && rv[idx]) g = idx;
            end
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(inflt));
         chk("rsp_valid", 64'(rsp_valid), 64'(inflt && (cyc - acc_cyc >= int'(SETTLE) + 1)));
         if (inflt) begin
            chk("add_a", 64'(add_a), 64'(cur_a));
            chk("add_b", 64'(add_b), 64'(cur_b));
            chk("add_cin", 64'(add_cin), 64'(cur_c));
         end
         if (prev_rv && rsp_valid) begin
            chk("hold_id", 64'(rsp_id), 64'(h_id));
            chk("hold_sum", 64'(rsp_sum), 64'(h_sum));
            chk("hold_cout", 64'(rsp_cout), 64'(h_cout));
         end
         prev_rv = rsp_valid;
         h_id    = rsp_id;
         h_sum   = rsp_sum;
         h_cout  = rsp_cout;
         if (rsp_valid && rsp_ready && inflt) begin
            chk("rsp_id", 64'(rsp_id), 64'(cur_id));
            chk("rsp_sum", 64'(rsp_sum), 64'(cur_res[31:0]));
            chk("rsp_cout", 64'(rsp_cout), 64'(cur_res[32]));
            last_id   = rsp_id;
            last_sum  = rsp_sum;
            last_cout = rsp_cout;
            rsp_cnt++;
            inflt = 0;
         end
         if (g >= 0) begin
            for (int i = 0; i < NREQ; i++) if (i != g && rv[i]) wait_n[i]++;
            chk("fairness", 64'(wait_n[g] < int'(NREQ)), 64'd1);
            wait_n[g] = 0;
            cur_id  = g;
            cur_a   = ra[32*g +: 32];
            cur_b   = rb[32*g +: 32];
            cur_c   = rc[g];
            cur_res = {1'b0, cur_a} + {1'b0, cur_b} + 33'(cur_c);
            inflt   = 1;
            acc_cyc = cyc;
            mptr    = (g + 1) % NREQ;
            glog.push_back(g);
            acc_log.push_back(cyc);
         end
         for (int i = 0; i < NREQ; i++) if (!rv[i]) wait_n[i] = 0;
      end
   end

   logic [NREQ-1:0] acc_v;

   task automatic tick();
      @(negedge clk);
      acc_v = rv & req_ready;
      @(posedge clk);
      #1;
      rv = rv & ~acc_v;
   endtask

   task automatic present(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
      ra[32*i +: 32] = a;
      rb[32*i +: 32] = b;
      rc[i]          = c;
      rv[i]          = 1'b1;
   endtask

   task automatic wait_rsp(input int max_cyc);
      int start;
      int n;
      start = rsp_cnt;
      n     = 0;
      while (rsp_cnt == start && n < max_cyc) begin
         tick();
         n++;
      end
      chk("rsp_seen", 64'(rsp_cnt - start), 64'd1);
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_add_a"}, 64'(add_a), 64'd0);
      chk({tag, "_add_b"}, 64'(add_b), 64'd0);
      chk({tag, "_add_cin"}, 64'(add_cin), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
      chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'd0);
      chk({tag, "_rsp_cout"}, 64'(rsp_cout), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      rst = 1'b1; rv = '0; rc = '0; ra = '0; rb = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      outputs_zero("reset");
      rst = 1'b0;
      rsp_ready = 1'b1;

      // Single request
      present(0, 32'h5, 32'h3, 1'b0);
      wait_rsp(20);
      chk("t1_id", 64'(last_id), 64'd0);
      chk("t1_sum", 64'(last_sum), 64'h8);
      chk("t1_cout", 64'(last_cout), 64'd0);

      // Carry-out and wrap
      present(2, 32'hFFFF_FFFF, 32'h0, 1'b1);
      wait_rsp(20);
      chk("t2_id", 64'(last_id), 64'd2);
      chk("t2_sum", 64'(last_sum), 64'h0);
      chk("t2_cout", 64'(last_cout), 64'd1);

      // Pointer now 3: requesters 1 and 3 contend
      base = glog.size();
      present(1, 32'h10, 32'h20, 1'b0);
      present(3, 32'h30, 32'h40, 1'b1);
      wait_rsp(20);
      wait_rsp(20);
      chk("t3_count", 64'(glog.size() - base), 64'd2);
      if (glog.size() >= base + 2) begin
         chk("t3_first", 64'(glog[base]), 64'd3);
         chk("t3_second", 64'(glog[base+1]), 64'd1);
      end

      // Backpressure
      rsp_ready = 1'b0;
      present(0, 32'hAAAA_0000, 32'h0000_5555, 1'b0);
      present(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk("t4_valid", 64'(rsp_valid), 64'd1);
      base = glog.size();
      repeat (5) tick();
      chk("t4_no_grant", 64'(glog.size() - base), 64'd0);
      chk("t4_still_valid", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      wait_rsp(5);
      chk("t4_first_id", 64'(last_id), 64'd2);
      chk("t4_first_cout", 64'(last_cout), 64'd1);
      wait_rsp(20);
      chk("t4_second_id", 64'(last_id), 64'd0);

      // Mid-operation reset while requester 1 is in ADD
      present(1, $urandom, $urandom, 1'b1);
      tick();
      chk("t5_busy", 64'(busy), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      outputs_zero("t5_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      base = rsp_cnt;
      present(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      present(3, 32'h1, 32'h1, 1'b0);
      wait_rsp(20);
      chk("t5_none_before", 64'(rsp_cnt - base), 64'd1);
      chk("t5_id", 64'(last_id), 64'd0);
      chk("t5_sum", 64'(last_sum), 64'h2345_6789);
      wait_rsp(20);
      chk("t5_next_id", 64'(last_id), 64'd3);

      // Round-robin from pointer 0 with everyone requesting continuously
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) present(i, $urandom, $urandom, 1'($urandom));
      base = glog.size();
      n = 0;
      while (glog.size() < base + 5 && n < 60) begin
         tick();
         for (int i = 0; i < NREQ; i++) if (acc_v[i]) present(i, $urandom, $urandom, 1'($urandom));
         n++;
      end
      rv = '0;
      chk("rr_count", 64'(glog.size() >= base + 5), 64'd1);
      if (glog.size() >= base + 5) begin
         for (int k = 0; k < 5; k++) chk("rr_id", 64'(glog[base+k]), 64'(k % NREQ));
         for (int k = 0; k < 4; k++)
            chk("rr_interval", 64'(acc_log[base+k+1] - acc_log[base+k]), 64'(SETTLE + 2));
      end
      wait_rsp(20);

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] && $urandom_range(0, 3) == 0) present(i, rnd32(), rnd32(), 1'($urandom));
            else if (rv[i] && $urandom_range(0, 31) == 0) rv[i] = 1'b0;
         end
         tick();
      end
      rv = '0;
      rsp_ready = 1'b1;
      repeat (SETTLE + 4) tick();
      chk("drain_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
